// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Purpose : bundles the per-stage hazard fields a 5-stage pipeline presents to
//           its hazard controller, and the control answers that come back.
//
// Contract: there is no valid/ready handshake on this bundle. The pipeline
//           drives every stage field on every cycle, bubbles included. A bubble
//           carries reg_write_*=0, result_src_e=0 and mc_start_e=0. The
//           controller answers combinationally in the same cycle. The
//           pipeline registers apply the stall, flush and bubble controls on
//           the next rising edge.
//
// Modports:
//   master : the pipeline datapath (drives stage fields, receives controls)
//   slave  : the hazard controller (receives stage fields, drives controls)
//
// Signals:
//   rs1_d, rs2_d         decode-stage source registers
//   rs1_e, rs2_e, rd_e   execute-stage sources / destination
//   result_src_e         execute-stage instruction is a load
//   reg_write_m/_w       write enables in memory / writeback stages
//   rd_m, rd_w           destinations in memory / writeback stages
//   pc_src_e             branch/jump taken in execute
//   mc_start_e           multi-cycle op present in execute
//   forward_a_e/_b_e     operand select: 00 regfile, 01 writeback, 10 memory
//   stall_f/_d/_e        hold fetch / decode / execute registers
//   flush_d/_e           clear decode / execute registers to a bubble
//   bubble_m             load a bubble into the memory register
//   mc_busy              multi-cycle FSM is in BUSY (FSM state visibility)
//   stall_count          saturating count of fetch-stall cycles
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
);
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rs1_e;
  logic [REG_ADDR_W-1:0] rs2_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [REG_ADDR_W-1:0] rd_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  result_src_e;
  logic                  reg_write_m;
  logic                  reg_write_w;
  logic                  pc_src_e;
  logic                  mc_start_e;

  logic [1:0]            forward_a_e;
  logic [1:0]            forward_b_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  stall_e;
  logic                  flush_d;
  logic                  flush_e;
  logic                  bubble_m;
  logic                  mc_busy;
  logic [PERF_W-1:0]     stall_count;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output result_src_e, reg_write_m, reg_write_w, pc_src_e, mc_start_e,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
    input  flush_d, flush_e, bubble_m, mc_busy, stall_count
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  result_src_e, reg_write_m, reg_write_w, pc_src_e, mc_start_e,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
    output flush_d, flush_e, bubble_m, mc_busy, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose : hazard unit for a 5-stage pipeline. It provides operand
//           forwarding, load-use stalls, branch flushes, and a two-state FSM.
//           The FSM holds the pipeline while a multi-cycle op occupies
//           execute for MC_LATENCY cycles. It also keeps a saturating
//           counter of fetch-stall cycles.
//
// Parameters:
//   REG_ADDR_W  register-index width
//   MC_LATENCY  execute occupancy of a multi-cycle op, 2..16
//   PERF_W      stall_count width
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset. While high it also forces every
//        output to 0 combinationally.
//   hz   pipeline_hazard_ctrl_if.slave (stage fields in, controls out)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CNT_W = $clog2(MC_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  mc_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_stall;
  logic             lw_stall;
  logic             run;
  logic             stall_f_int;

  // A memory-stage match is the younger producer, so it has priority.
  // Register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (hz.reg_write_m && (hz.rd_m != '0) && (hz.rd_m == rs)) begin
      sel = 2'b10;
    end else if (hz.reg_write_w && (hz.rd_w != '0) && (hz.rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and mc_stall. The op stalls in its start cycle and then in
  // every BUSY cycle except the last (cnt==1). This gives MC_LATENCY-1
  // stall cycles. In that last cycle the op completes and the pipeline
  // moves on. pc_src_e is deliberately not an input here: a taken branch
  // during a multi-cycle stall is illegal and must not disturb the
  // sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.mc_start_e) begin
          state_d  = BUSY;
          cnt_d    = CNT_LOAD;
          mc_stall = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          mc_stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // While the multi-cycle FSM holds decode, the load-use check cannot
  // also flush execute, because that would destroy the op in flight.
  assign lw_stall = hz.result_src_e && (hz.rd_e != '0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d)) &&
                    !mc_stall;

  // rst gates every output without waiting for a clock edge.
  assign run         = !rst;
  assign stall_f_int = run && (lw_stall || mc_stall) && !hz.pc_src_e;

  assign hz.forward_a_e = run ? fwd_sel(hz.rs1_e) : 2'b00;
  assign hz.forward_b_e = run ? fwd_sel(hz.rs2_e) : 2'b00;
  assign hz.stall_f     = stall_f_int;
  assign hz.stall_d     = run && (lw_stall || mc_stall) && !hz.pc_src_e;
  assign hz.stall_e     = run && mc_stall;
  assign hz.bubble_m    = run && mc_stall;
  assign hz.flush_d     = run && hz.pc_src_e;
  assign hz.flush_e     = run && (hz.pc_src_e || lw_stall);
  assign hz.mc_busy     = run && (state_q == BUSY);

  // Fetch-stall performance counter. It saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz.stall_count <= '0;
    end else if (stall_f_int && (hz.stall_count != '1)) begin
      hz.stall_count <= hz.stall_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int L  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .PERF_W(32)) hif ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .PERF_W(3))  hif3 ();

  // The narrow-counter instance sees exactly the same stage fields.
  assign hif3.rs1_d        = hif.rs1_d;
  assign hif3.rs2_d        = hif.rs2_d;
  assign hif3.rs1_e        = hif.rs1_e;
  assign hif3.rs2_e        = hif.rs2_e;
  assign hif3.rd_e         = hif.rd_e;
  assign hif3.rd_m         = hif.rd_m;
  assign hif3.rd_w         = hif.rd_w;
  assign hif3.result_src_e = hif.result_src_e;
  assign hif3.reg_write_m  = hif.reg_write_m;
  assign hif3.reg_write_w  = hif.reg_write_w;
  assign hif3.pc_src_e     = hif.pc_src_e;
  assign hif3.mc_start_e   = hif.mc_start_e;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MC_LATENCY(L), .PERF_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MC_LATENCY(L), .PERF_W(3)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .hz  (hif3)
  );

  // ---------------- scoreboard / model state ----------------
  // Control vector: {fa[1:0], fb[1:0], sf, sd, se, fd, fe, bm, busy}
  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          op_age   = 0;   // cycles since the start cycle of the op in flight; 0 = none
  longint      cnt32    = 0;
  int          cnt3     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [10:0] obs_vec();
    return {hif.forward_a_e, hif.forward_b_e, hif.stall_f, hif.stall_d, hif.stall_e,
            hif.flush_d, hif.flush_e, hif.bubble_m, hif.mc_busy};
  endfunction

  function automatic logic [10:0] obs_vec3();
    return {hif3.forward_a_e, hif3.forward_b_e, hif3.stall_f, hif3.stall_d, hif3.stall_e,
            hif3.flush_d, hif3.flush_e, hif3.bubble_m, hif3.mc_busy};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (hif.reg_write_m && hif.rd_m != 0 && hif.rd_m == rs) return 2'b10;
    if (hif.reg_write_w && hif.rd_w != 0 && hif.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Reference: a multi-cycle op occupies execute for L cycles (age 0..L-1)
  // and stalls the pipe in all but its final cycle.
  function automatic logic [10:0] model_eval();
    bit busy, mc, lw, pc, stl;
    busy = (op_age >= 1);
    mc   = busy ? (op_age < L - 1) : hif.mc_start_e;
    lw   = hif.result_src_e && (hif.rd_e != 0) &&
           ((hif.rd_e == hif.rs1_d) || (hif.rd_e == hif.rs2_d)) && !mc;
    pc   = hif.pc_src_e;
    stl  = (lw || mc) && !pc;
    return {ref_fwd(hif.rs1_e), ref_fwd(hif.rs2_e), stl, stl, mc, pc, pc || lw, mc, busy};
  endfunction

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [10:0] e;
    @(negedge clk);
    e = model_eval();
    exp_q.push_back(e);
    check("ctl", 64'(obs_vec()), 64'(exp_q.pop_front()));
    check("ctl_sat", 64'(obs_vec3()), 64'(e));
    check("stall_count", 64'(hif.stall_count), 64'(cnt32));
    check("stall_count_sat", 64'(hif3.stall_count), 64'(cnt3));
    @(posedge clk);
    if (e[6]) begin
      if (cnt32 < 64'hffff_ffff) cnt32++;
      if (cnt3 < 7) cnt3++;
    end
    if (op_age >= 1) op_age = (op_age == L - 1) ? 0 : op_age + 1;
    else             op_age = hif.mc_start_e ? 1 : 0;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    hif.rs1_d = '0; hif.rs2_d = '0; hif.rs1_e = '0; hif.rs2_e = '0;
    hif.rd_e = '0; hif.rd_m = '0; hif.rd_w = '0;
    hif.result_src_e = 1'b0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
    hif.pc_src_e = 1'b0; hif.mc_start_e = 1'b0;
  endtask

  task automatic drive_random();
    hif.rs1_d = AW'($urandom_range(0, 3)); hif.rs2_d = AW'($urandom_range(0, 3));
    hif.rs1_e = AW'($urandom_range(0, 3)); hif.rs2_e = AW'($urandom_range(0, 3));
    hif.rd_e  = AW'($urandom_range(0, 3)); hif.rd_m  = AW'($urandom_range(0, 3));
    hif.rd_w  = AW'($urandom_range(0, 3));
    hif.result_src_e = ($urandom_range(0, 2) == 0);
    hif.reg_write_m  = $urandom_range(0, 1) != 0;
    hif.reg_write_w  = $urandom_range(0, 1) != 0;
    hif.pc_src_e     = ($urandom_range(0, 5) == 0);
    hif.mc_start_e   = ($urandom_range(0, 4) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit [3:0] se_tbl;
    bit [3:0] busy_tbl;
    // Reset with noisy inputs: all outputs must read 0.
    rst = 1'b1;
    drive_idle();
    hif.mc_start_e = 1'b1; hif.reg_write_m = 1'b1; hif.rd_m = 5'd5; hif.rs1_e = 5'd5;
    hif.result_src_e = 1'b1; hif.rd_e = 5'd7; hif.rs1_d = 5'd7;
    #3;
    check("reset_ctl", 64'(obs_vec()), 64'd0);
    check("reset_count", 64'(hif.stall_count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b0;
    #1;
    check("post_reset_busy", 64'(hif.mc_busy), 64'd0);

    // Forwarding priority and register-0 exclusion.
    hif.reg_write_m = 1'b1; hif.rd_m = 5'd5; hif.reg_write_w = 1'b1; hif.rd_w = 5'd5;
    hif.rs1_e = 5'd5;
    #1 check("fwd_a_mem", 64'(hif.forward_a_e), 64'd2);
    hif.rd_m = 5'd0;
    #1 check("fwd_a_wb", 64'(hif.forward_a_e), 64'd1);
    hif.rs1_e = 5'd0;
    #1 check("fwd_a_rf", 64'(hif.forward_a_e), 64'd0);
    hif.rs2_e = 5'd5; hif.rd_m = 5'd5;
    #1 check("fwd_b_mem", 64'(hif.forward_b_e), 64'd2);
    cycle();
    drive_idle();

    // Load-use stall for one cycle.
    hif.result_src_e = 1'b1; hif.rd_e = 5'd7; hif.rs2_d = 5'd7;
    #1;
    check("lw_stall_f", 64'(hif.stall_f), 64'd1);
    check("lw_stall_d", 64'(hif.stall_d), 64'd1);
    check("lw_flush_e", 64'(hif.flush_e), 64'd1);
    cycle();
    drive_idle();
    #1 check("lw_count", 64'(hif.stall_count), 64'd1);

    // Multi-cycle op with mc_start_e held: stalls in 0..2, busy in 1..3, restart in 4.
    se_tbl   = 4'b0111;  // bit i = cycle i
    busy_tbl = 4'b1110;
    hif.mc_start_e = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("mc_stall_e_c%0d", c), 64'(hif.stall_e), 64'((c == 4) ? 1'b1 : se_tbl[c]));
      check($sformatf("mc_bubble_c%0d", c), 64'(hif.bubble_m), 64'((c == 4) ? 1'b1 : se_tbl[c]));
      check($sformatf("mc_busy_c%0d", c), 64'(hif.mc_busy), 64'((c == 4) ? 1'b0 : busy_tbl[c]));
      cycle();
    end
    hif.mc_start_e = 1'b0;
    for (int c = 0; c < 4; c++) cycle();

    // Taken branch overrides a load-use stall.
    hif.result_src_e = 1'b1; hif.rd_e = 5'd7; hif.rs1_d = 5'd7; hif.pc_src_e = 1'b1;
    #1;
    check("br_flush_d", 64'(hif.flush_d), 64'd1);
    check("br_flush_e", 64'(hif.flush_e), 64'd1);
    check("br_stall_f", 64'(hif.stall_f), 64'd0);
    check("br_stall_d", 64'(hif.stall_d), 64'd0);
    cycle();
    drive_idle();

    // Asynchronous reset in BUSY cycle 1.
    hif.mc_start_e = 1'b1;
    cycle();
    hif.mc_start_e = 1'b0;
    #1 check("pre_rst_busy", 64'(hif.mc_busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_ctl", 64'(obs_vec()), 64'd0);
    check("async_rst_count", 64'(hif.stall_count), 64'd0);
    op_age = 0; cnt32 = 0; cnt3 = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rel_busy", 64'(hif.mc_busy), 64'd0);
    check("rel_count", 64'(hif.stall_count), 64'd0);

    // Nine consecutive load-use stalls: the 3-bit counter saturates at 7.
    hif.result_src_e = 1'b1; hif.rd_e = 5'd3; hif.rs1_d = 5'd3;
    for (int c = 0; c < 9; c++) cycle();
    drive_idle();
    #1;
    check("sat_count3", 64'(hif3.stall_count), 64'd7);
    check("sat_count32", 64'(hif.stall_count), 64'd9);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      drive_random();
      cycle();
    end
    drive_idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
